// File: rtl/vector_wb_seq.sv
// ============================================================================
// Module   : vector_wb_seq
// Brief    : Vector register-file writeback sequencer. Splits an LMUL register
//            group into NPORT-wide write beats with vl/SEW tail strobing and
//            reduction-scalar writes. Optional macro VECTOR_WB_PEND_EN adds a
//            per-register pending mask output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_wb_seq #(
    parameter int VLEN    = 128,
    parameter int NPORT   = 4,
    parameter int MAXLMUL = 8,
    parameter int VLW     = $clog2(VLEN*MAXLMUL/8) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                in_vd,
    input  logic [1:0]                in_lmul,
    input  logic [1:0]                in_sew,
    input  logic                      in_red,
    input  logic [VLW-1:0]            in_vl,
    input  logic [VLEN*MAXLMUL-1:0]   in_data,
    output logic [NPORT-1:0]          rf_wen,
    output logic [NPORT*5-1:0]        rf_waddr,
    output logic [NPORT*VLEN/8-1:0]   rf_wstrb,
    output logic [NPORT*VLEN-1:0]     rf_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      misalign
`ifdef VECTOR_WB_PEND_EN
    ,
    output logic [31:0]               pend_mask
`endif
);

    localparam int         c_BPR         = VLEN / 8;
    localparam int         c_LOG_NPORT   = $clog2(NPORT);
    localparam int         c_LOG_MAXLMUL = $clog2(MAXLMUL);
    localparam int         c_MAXBEATS    = MAXLMUL / NPORT;
    localparam int         c_BW          = (c_MAXBEATS > 1) ? $clog2(c_MAXBEATS) : 1;
    localparam int         c_VBW         = VLW + 3;
    localparam logic [1:0] c_LMUL_CAP    = 2'(c_LOG_MAXLMUL);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_BW-1:0]         r_beat;
    logic [c_BW-1:0]         r_last;
    logic [4:0]              r_vd;
    logic [1:0]              r_lmul;
    logic [1:0]              r_sew;
    logic                    r_red;
    logic [VLW-1:0]          r_vl;
    logic [VLEN*MAXLMUL-1:0] r_data;

    logic                    w_accept;
    logic                    w_final;
    logic [1:0]              w_lmul;
    logic [4:0]              w_nreg;
    logic [VLW-1:0]          w_vlmax;
    logic [VLW-1:0]          w_vl;
    logic [c_BW-1:0]         w_last;
    logic [4:0]              w_rnreg;
    logic [c_VBW-1:0]        w_vbytes;
    logic [NPORT-1:0]        w_act;

    function automatic int reg_idx(input logic [c_BW-1:0] beat, input int p);
        return int'(beat) * NPORT + p;
    endfunction

    // Accept-side decode: clamp vl to VLMAX and size the beat count up front.
    always_comb begin
        w_lmul  = (in_lmul > c_LMUL_CAP) ? c_LMUL_CAP : in_lmul;
        w_nreg  = 5'd1 << w_lmul;
        w_vlmax = VLW'((int'(w_nreg) * c_BPR) >> in_sew);
        w_vl    = (in_vl > w_vlmax) ? w_vlmax : in_vl;
        if (in_red || (int'(w_lmul) <= c_LOG_NPORT))
            w_last = '0;
        else
            w_last = c_BW'((1 << (int'(w_lmul) - c_LOG_NPORT)) - 1);
    end

    assign w_final  = (r_state == S_WRITE) && (r_beat == r_last);
    assign in_ready = (r_state == S_IDLE) || w_final;
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state == S_WRITE);
    assign done     = w_final;
    assign misalign = w_accept && !in_red && (|(in_vd & (w_nreg - 5'd1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_last  <= '0;
            r_vd    <= '0;
            r_lmul  <= '0;
            r_sew   <= '0;
            r_red   <= 1'b0;
            r_vl    <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_state <= S_WRITE;
            r_beat  <= '0;
            r_last  <= w_last;
            r_vd    <= in_vd;
            r_lmul  <= w_lmul;
            r_sew   <= in_sew;
            r_red   <= in_red;
            r_vl    <= w_vl;
            r_data  <= in_data;
        end else if (r_state == S_WRITE) begin
            if (w_final) begin
                r_state <= S_IDLE;
                r_beat  <= '0;
            end else begin
                r_beat  <= r_beat + 1'b1;
            end
        end
    end

    // Write-port decode from registered state only; inactive ports drive zeros.
    always_comb begin
        w_rnreg  = 5'd1 << r_lmul;
        w_vbytes = c_VBW'(r_vl) << r_sew;
        rf_wen   = '0;
        rf_waddr = '0;
        rf_wstrb = '0;
        rf_wdata = '0;
        w_act    = '0;
        if (r_state == S_WRITE) begin
            if (r_red) begin
                w_act[0] = 1'b1;
                if (r_vl != '0) begin
                    rf_wen[0]          = 1'b1;
                    rf_waddr[4:0]      = r_vd;
                    rf_wdata[VLEN-1:0] = r_data[VLEN-1:0];
                    for (int b = 0; b < c_BPR; b++)
                        rf_wstrb[b] = (b < (1 << r_sew));
                end
            end else begin
                for (int p = 0; p < NPORT; p++) begin
                    if (reg_idx(r_beat, p) < int'(w_rnreg)) begin
                        w_act[p] = 1'b1;
                        if (r_vl != '0) begin
                            rf_wen[p]                = 1'b1;
                            rf_waddr[p*5 +: 5]       = r_vd + 5'(reg_idx(r_beat, p));
                            rf_wdata[p*VLEN +: VLEN] = r_data[reg_idx(r_beat, p)*VLEN +: VLEN];
                            for (int b = 0; b < c_BPR; b++)
                                rf_wstrb[p*c_BPR + b] =
                                    ((reg_idx(r_beat, p) * c_BPR + b) < int'(w_vbytes));
                        end
                    end
                end
            end
        end
    end

`ifdef VECTOR_WB_PEND_EN
    logic [31:0] r_pend;
    logic [31:0] w_set;
    logic [31:0] w_clr;

    // Clears follow beat issue (not wen), so a vl==0 result still retires its bits.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_accept) begin
            if (in_red) begin
                w_set[in_vd] = 1'b1;
            end else begin
                for (int j = 0; j < MAXLMUL; j++)
                    if (j < int'(w_nreg))
                        w_set[in_vd + 5'(j)] = 1'b1;
            end
        end
        for (int p = 0; p < NPORT; p++)
            if (w_act[p])
                w_clr[r_vd + (r_red ? 5'd0 : 5'(reg_idx(r_beat, p)))] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pend <= '0;
        else
            r_pend <= (r_pend & ~w_clr) | w_set;
    end

    assign pend_mask = r_pend;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_wb_seq.sv
// ============================================================================
// Module   : tb_vector_wb_seq
// Brief    : Self-checking bench for vector_wb_seq: directed vector table,
//            multi-cycle corner sequences and randomized traffic vs a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_wb_seq;

    localparam int VLEN    = 128;
    localparam int NPORT   = 4;
    localparam int MAXLMUL = 8;
    localparam int VLW     = 8;
    localparam int BPR     = VLEN / 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [4:0]              in_vd = '0;
    logic [1:0]              in_lmul = '0;
    logic [1:0]              in_sew = '0;
    logic                    in_red = 1'b0;
    logic [VLW-1:0]          in_vl = '0;
    logic [VLEN*MAXLMUL-1:0] in_data = '0;
    logic [NPORT-1:0]        rf_wen;
    logic [NPORT*5-1:0]      rf_waddr;
    logic [NPORT*BPR-1:0]    rf_wstrb;
    logic [NPORT*VLEN-1:0]   rf_wdata;
    logic                    busy;
    logic                    done;
    logic                    misalign;
`ifdef VECTOR_WB_PEND_EN
    logic [31:0]             pend_mask;
`endif

    vector_wb_seq #(.VLEN(VLEN), .NPORT(NPORT), .MAXLMUL(MAXLMUL), .VLW(VLW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vd    (in_vd),
        .in_lmul  (in_lmul),
        .in_sew   (in_sew),
        .in_red   (in_red),
        .in_vl    (in_vl),
        .in_data  (in_data),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wstrb (rf_wstrb),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .done     (done),
        .misalign (misalign)
`ifdef VECTOR_WB_PEND_EN
        ,
        .pend_mask(pend_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPORT-1:0]      wen;
        logic [NPORT*5-1:0]    waddr;
        logic [NPORT*BPR-1:0]  wstrb;
        logic [NPORT*VLEN-1:0] wdata;
        logic [31:0]           clr;
    } beat_t;

    typedef struct {
        logic [4:0]  vd;
        logic [1:0]  lmul;
        logic [1:0]  sew;
        logic        red;
        logic [7:0]  vl;
        int          nb;
        logic        mis;
        logic [3:0]  wen0;
        logic [15:0] strb0;
        logic [15:0] strb1;
    } vec_t;

    beat_t       exp_q[$];
    logic [31:0] exp_pend = '0;
    int          acc_cnt = 0;
    int          ncmp = 0;
    int          nfail = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a result is a list of register writes laid out over a
    // flat byte-enable range, chunked NPORT registers per beat.
    task automatic push_txn(input logic [4:0] vd, input logic [1:0] lmul, input logic [1:0] sew,
                            input logic red, input logic [7:0] vl_in, input logic [1023:0] data);
        int nreg, vlmax, vl, nbytes, nb, i;
        logic [4:0] a;
        beat_t bt;
        nreg   = 1 << lmul;
        vlmax  = (nreg * BPR) >> sew;
        vl     = (int'(vl_in) < vlmax) ? int'(vl_in) : vlmax;
        nbytes = vl << sew;
        if (red) begin
            bt = '{default: '0};
            bt.clr[vd] = 1'b1;
            exp_pend[vd] = 1'b1;
            if (vl != 0) begin
                bt.wen[0]        = 1'b1;
                bt.waddr[4:0]    = vd;
                bt.wdata[127:0]  = data[127:0];
                for (int b = 0; b < (1 << sew); b++) bt.wstrb[b] = 1'b1;
            end
            exp_q.push_back(bt);
        end else begin
            nb = (nreg + NPORT - 1) / NPORT;
            for (int k = 0; k < nb; k++) begin
                bt = '{default: '0};
                for (int p = 0; p < NPORT; p++) begin
                    i = k * NPORT + p;
                    if (i < nreg) begin
                        a = 5'((int'(vd) + i) % 32);
                        bt.clr[a] = 1'b1;
                        exp_pend[a] = 1'b1;
                        if (vl != 0) begin
                            bt.wen[p]               = 1'b1;
                            bt.waddr[p*5 +: 5]      = a;
                            bt.wdata[p*VLEN +: VLEN] = data[i*VLEN +: VLEN];
                            for (int b = 0; b < BPR; b++)
                                bt.wstrb[p*BPR + b] = ((i * BPR + b) < nbytes);
                        end
                    end
                end
                exp_q.push_back(bt);
            end
        end
    endtask

    always @(posedge clk) begin
        bit mready;
        if (!rst_n) begin
            exp_q.delete();
            exp_pend = '0;
        end else begin
            mready = (exp_q.size() <= 1);
            if (exp_q.size() > 0) begin
                exp_pend = exp_pend & ~exp_q[0].clr;
                void'(exp_q.pop_front());
            end
            if (in_valid && mready) begin
                push_txn(in_vd, in_lmul, in_sew, in_red, in_vl, in_data);
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        beat_t cur;
        logic  exp_mis;
        logic [4:0] nm;
        #1;
        if (!rst_n) begin
            chk("rst_wen", rf_wen, 0);
            chk("rst_waddr", rf_waddr, 0);
            chk("rst_wstrb", rf_wstrb, 0);
            chk("rst_wdata", rf_wdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_misalign", misalign, 0);
            chk("rst_ready", in_ready, 1);
`ifdef VECTOR_WB_PEND_EN
            chk("rst_pend", pend_mask, 0);
`endif
        end else begin
            nm = (5'd1 << in_lmul) - 5'd1;
            exp_mis = in_valid && (exp_q.size() <= 1) && !in_red && ((in_vd & nm) != 0);
            chk("in_ready", in_ready, exp_q.size() <= 1);
            chk("misalign", misalign, exp_mis);
            chk("busy", busy, exp_q.size() > 0);
            chk("done", done, exp_q.size() == 1);
            if (exp_q.size() > 0) begin
                cur = exp_q[0];
                chk("wen", rf_wen, cur.wen);
                for (int p = 0; p < NPORT; p++) begin
                    if (cur.wen[p]) begin
                        chk("waddr", rf_waddr[p*5 +: 5], cur.waddr[p*5 +: 5]);
                        chk("wstrb", rf_wstrb[p*BPR +: BPR], cur.wstrb[p*BPR +: BPR]);
                        chk("wdata", rf_wdata[p*VLEN +: VLEN], cur.wdata[p*VLEN +: VLEN]);
                    end
                end
            end else begin
                chk("idle_wen", rf_wen, 0);
            end
`ifdef VECTOR_WB_PEND_EN
            chk("pend_mask", pend_mask, exp_pend);
`endif
        end
    end

    task automatic rand_data();
        for (int w = 0; w < 32; w++) in_data[w*32 +: 32] = $urandom;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #2;
        chk("drain_busy", busy, 0);
    endtask

    task automatic send_vec(input vec_t v);
        int nb;
        @(negedge clk);
        in_vd = v.vd; in_lmul = v.lmul; in_sew = v.sew; in_red = v.red; in_vl = v.vl;
        rand_data();
        in_valid = 1'b1;
        #2;
        chk("tbl_misalign", misalign, v.mis);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("tbl_wen0", rf_wen, v.wen0);
        if (v.wen0[0]) chk("tbl_strb_p0", rf_wstrb[15:0], v.strb0);
        if (v.wen0[1]) chk("tbl_strb_p1", rf_wstrb[31:16], v.strb1);
        nb = 0;
        for (int c = 0; c < 16; c++) begin
            if (busy) nb++;
            if (done) break;
            @(negedge clk);
            #2;
        end
        chk("tbl_beats", nb, v.nb);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   last_acc;
        //            vd     lmul  sew   red   vl      nb mis   wen0   strb0     strb1
        tbl[0] = '{5'd8,  2'd3, 2'd2, 1'b0, 8'd32,  2, 1'b0, 4'hF, 16'hFFFF, 16'hFFFF};
        tbl[1] = '{5'd4,  2'd1, 2'd0, 1'b0, 8'd20,  1, 1'b0, 4'h3, 16'hFFFF, 16'h000F};
        tbl[2] = '{5'd3,  2'd2, 2'd2, 1'b1, 8'd5,   1, 1'b0, 4'h1, 16'h000F, 16'h0000};
        tbl[3] = '{5'd30, 2'd2, 2'd1, 1'b0, 8'd32,  1, 1'b1, 4'hF, 16'hFFFF, 16'hFFFF};
        tbl[4] = '{5'd0,  2'd3, 2'd0, 1'b0, 8'd0,   2, 1'b0, 4'h0, 16'h0000, 16'h0000};
        tbl[5] = '{5'd16, 2'd0, 2'd3, 1'b0, 8'd200, 1, 1'b0, 4'h1, 16'hFFFF, 16'h0000};
        tbl[6] = '{5'd2,  2'd1, 2'd3, 1'b0, 8'd3,   1, 1'b0, 4'h3, 16'hFFFF, 16'h00FF};
        tbl[7] = '{5'd5,  2'd0, 2'd0, 1'b1, 8'd0,   1, 1'b0, 4'h0, 16'h0000, 16'h0000};
        tbl[8] = '{5'd9,  2'd3, 2'd3, 1'b1, 8'd7,   1, 1'b0, 4'h1, 16'h00FF, 16'h0000};
        tbl[9] = '{5'd12, 2'd3, 2'd1, 1'b0, 8'd100, 2, 1'b1, 4'hF, 16'hFFFF, 16'hFFFF};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            wait_idle();
            send_vec(tbl[t]);
        end

        // Back-to-back: two lmul=8 results with in_valid held high.
        wait_idle();
        @(negedge clk);
        in_vd = 5'd0; in_lmul = 2'd3; in_sew = 2'd0; in_red = 1'b0; in_vl = 8'd128;
        rand_data();
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_vd = 5'd16; in_sew = 2'd1; in_vl = 8'd64;
        rand_data();
        #2;
        chk("b2b_ready_b0", in_ready, 0);
        chk("b2b_wen_b0", rf_wen, 4'hF);
        @(negedge clk);
        #2;
        chk("b2b_ready_b1", in_ready, 1);
        chk("b2b_wen_b1", rf_wen, 4'hF);
        chk("b2b_done_b1", done, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("b2b_ready_b2", in_ready, 0);
        chk("b2b_wen_b2", rf_wen, 4'hF);
        chk("b2b_addr_b2", rf_waddr[4:0], 5'd16);
        @(negedge clk);
        #2;
        chk("b2b_ready_b3", in_ready, 1);
        chk("b2b_wen_b3", rf_wen, 4'hF);
        chk("b2b_done_b3", done, 1);
        @(negedge clk);
        #2;
        chk("b2b_idle_wen", rf_wen, 0);

        // Reset asserted during beat 0 of an lmul=8 result.
        wait_idle();
        @(negedge clk);
        in_vd = 5'd8; in_lmul = 2'd3; in_sew = 2'd2; in_red = 1'b0; in_vl = 8'd32;
        rand_data();
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_wen", rf_wen, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
`ifdef VECTOR_WB_PEND_EN
        chk("midrst_pend", pend_mask, 0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #2;
            chk("postrst_wen", rf_wen, 0);
            chk("postrst_busy", busy, 0);
        end

        // Randomized traffic with random gaps and back-to-back accepts.
        last_acc = acc_cnt;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (in_valid && (acc_cnt != last_acc)) in_valid = 1'b0;
            last_acc = acc_cnt;
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                in_vd   = 5'($urandom_range(0, 31));
                in_lmul = 2'($urandom_range(0, 3));
                in_sew  = 2'($urandom_range(0, 3));
                in_red  = ($urandom_range(0, 4) == 0);
                in_vl   = 8'($urandom_range(0, 140));
                rand_data();
                in_valid = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vector_wb_seq.md
Name: vector_wb_seq

Overview:
Parametrised vector register-file writeback sequencer. It accepts one completed vector result per handshake and writes it into the vector register file through NPORT parallel write ports.
- Supports LMUL 1/2/4/8 via multi-beat sequencing.
- Applies vl/SEW-based tail strobing and reduction-scalar writes.
- Sits between the execute/reduce stage and the VRF.

Parameters:
VLEN, 128, bits per vector register
NPORT, 4, VRF write ports driven per cycle (power of 2, 1..8)
MAXLMUL, 8, maximum register group size (power of 2, >= NPORT)
VLW, $clog2(VLEN*MAXLMUL/8)+1, width of vl input

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  result valid
in_ready  out  1  block can accept a result
in_vd  in  5  destination base register
in_lmul  in  2  0=1, 1=2, 2=4, 3=8 registers
in_sew  in  2  0=8b, 1=16b, 2=32b, 3=64b
in_red  in  1  reduction result: write element 0 only
in_vl  in  VLW  active element count
in_data  in  VLEN*MAXLMUL  result; register i of the group at bits [i*VLEN +: VLEN]
rf_wen  out  NPORT  per-port write enable
rf_waddr  out  NPORT*5  per-port register index
rf_wstrb  out  NPORT*VLEN/8  per-port byte strobes
rf_wdata  out  NPORT*VLEN  per-port write data
busy  out  1  sequencer in WRITE state
done  out  1  one-cycle pulse on the final beat of a result
misalign  out  1  one-cycle pulse at accept when in_vd is not a multiple of the group size

Behaviour:
- Reset (async): state IDLE, beat=0, all latched fields 0.
  - Reset output values: rf_wen/rf_waddr/rf_wstrb/rf_wdata=0, busy=0, done=0, misalign=0, in_ready=1.
- Accept: occurs when in_valid&in_ready.
  - Latch vd, lmul, sew, red, data, and clamped vl.
  - vl clamp: vl=min(in_vl, VLMAX), where VLMAX=(nreg*VLEN/8)>>sew and nreg=1<<lmul.
  - Go to WRITE with beat=0.
  - misalign pulses in the accept cycle when (in_vd & (nreg-1)) != 0.
- Latency: first write beat appears the cycle after accept. rf_* outputs are decoded from registered state only, with no input-to-output combinational path.
- Beat count: NB=ceil(nreg/NPORT) for a normal result; NB=1 when red=1.
- Port p at beat k:
  - Writes group register i=k*NPORT+p.
  - rf_wen[p]=1 iff i<nreg.
  - rf_waddr=(vd+i) mod 32; misaligned groups wrap rather than error.
  - rf_wdata=data[i*VLEN +: VLEN].
- Strobe rule: for byte b of register i, with global byte index g=i*VLEN/8+b, the strobe is set iff g < (vl<<sew). Tail bytes are left undisturbed.
- Reduction (red=1):
  - Only port 0 is active; waddr=vd; wdata=data[VLEN-1:0].
  - wstrb has its low (1<<sew) bytes set.
  - vl is ignored, except vl==0 gives wen=0.
- vl==0 (non-reduction): beats are still issued, with wen=0 on every port; done pulses normally.
- Ports whose strobe is all-zero still assert wen when i<nreg; the VRF honours the strobe.
- Final beat (k==NB-1): done=1.
  - in_ready=1 in the same cycle, which allows back-to-back accept.
  - If a new result is accepted then, the next cycle is beat 0 of the new result; otherwise the block goes to IDLE.
- in_ready = IDLE | final beat. busy=1 in WRITE.
- Reset mid-operation: the remaining beats are abandoned and no further writes are issued.

Optional Feature:
- Macro: VECTOR_WB_PEND_EN.
- When defined:
  - Extra output pend_mask[31:0] is added. At accept, the bits of all group registers (mod 32) are set.
  - Each bit clears in the cycle its write beat is issued, for all nreg registers regardless of strobe.
  - Bits set by a back-to-back accept are OR-ed in, and take priority over a same-cycle clear.
  - Reset value is 0.
- When not defined: the port is absent and no pending logic exists.

Test Plan:
- NPORT=4, lmul=3, vd=8, sew=2, vl=32 (VLMAX) → 2 beats.
  - Beat 0: waddr 8..11, all strobes 16'hFFFF.
  - Beat 1: waddr 12..15, all strobes 16'hFFFF; done on beat 1.
- lmul=1, vd=4, sew=0, vl=20 → 1 beat.
  - Port 0 wstrb=16'hFFFF; port 1 wstrb=16'h000F; ports 2-3 wen=0.
- red=1, sew=2, vd=3, lmul=2 → 1 beat.
  - Port 0 only: waddr=3, wstrb=16'h000F; misalign=0 because a reduction is a single register.
- lmul=2, vd=30 → misalign pulses at accept; waddr 30, 31, 0, 1.
- Back-to-back: hold in_valid continuously with two lmul=3 results.
  - Expect 4 consecutive write cycles with no bubble, and in_ready high only on beats 1 and 3.
- Assert rst_n low during beat 0 of an lmul=3 result.
  - All outputs go to 0 immediately, and no beat-1 write occurs after release.
  - pend_mask=0 when VECTOR_WB_PEND_EN is defined.
